dispenser_rr_scheduler: RTL

//  Shares one smart water dispenser (single pump/valve) between N_REQ taps. Picks one requester round-robin,

---
 rtl/dispenser_rr_scheduler_pkg.sv | 22 ++
 rtl/dispenser_rr_scheduler_rr_pick.sv | 38 +++
 rtl/dispenser_rr_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dispenser_rr_scheduler_pkg.sv
// Shared types and constants for the dispenser round-robin scheduler.
package dispenser_sched_pkg;

    // Width of the ack-timeout and cooldown counters.
    localparam int CNT_W = 8;

    // Scheduler phases for one dispense transaction.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_ACK   = 3'd2,
        DISPENSING = 3'd3,
        STOPPING   = 3'd4,
        COOLDOWN   = 3'd5
    } state_t;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dispenser_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module rr_pick
    import dispenser_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  rr_ptr_i,
    output logic [N_REQ-1:0] win_onehot_o,
    output logic [ID_W-1:0]  win_idx_o,
    output logic             any_o
);

    logic found;
    int   j;

    // Scan requesters starting at the pointer; the first hit owns the dispenser.
    always_comb begin
        win_onehot_o = '0;
        win_idx_o    = '0;
        found        = 1'b0;
        j            = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr_i) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req_i[j]) begin
                found           = 1'b1;
                win_onehot_o[j] = 1'b1;
                win_idx_o       = ID_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dispenser_rr_scheduler.sv
// Round-robin scheduler sharing one dispenser pump/valve between N_REQ taps.
// Handshake: disp_start/disp_stop are single-cycle pulses; the dispenser answers
// with the level disp_active. A tap holds req until granted; cancel is honoured
// only on the bit of the current owner. All outputs are registered.
module dispenser_rr_scheduler
    import dispenser_sched_pkg::*;
#(
    parameter  int N_REQ           = 4,
    parameter  int ACK_TIMEOUT     = 4,
    parameter  int COOLDOWN_CYCLES = 3,
    localparam int ID_W            = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] cancel,
    input  logic             disp_active,
    output logic             disp_start,
    output logic             disp_stop,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] COOL_LIM = CNT_W'(COOLDOWN_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               own_cancel;
    logic               enter_cool;
    logic [ID_W-1:0]    next_ptr;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i        (req),
        .rr_ptr_i     (rr_ptr_q),
        .win_onehot_o (pick_onehot),
        .win_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    assign own_cancel = cancel[gid_q];
    assign next_ptr   = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);

    // Next-state and next-output logic for one dispense transaction.
    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = ack_cnt_q;
        cool_cnt_d = cool_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        done_d     = 1'b0;
        fault_d    = fault_q;
        grant_d    = grant_q;
        gid_d      = gid_q;
        enter_cool = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = START;
                    start_d = 1'b1;
                    grant_d = pick_onehot;
                    gid_d   = pick_idx;
                end
            end
            START: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Cancel outranks a simultaneous acknowledge.
                if (own_cancel) begin
                    stop_d  = 1'b1;
                    state_d = STOPPING;
                end else if (disp_active) begin
                    state_d = DISPENSING;
                end else if (ack_cnt_q + CNT_W'(1) == ACK_LIM) begin
                    fault_d    = 1'b1;
                    enter_cool = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                end
            end
            DISPENSING: begin
                // A falling active is a normal end even if cancel arrives with it.
                if (!disp_active) begin
                    done_d     = 1'b1;
                    enter_cool = 1'b1;
                end else if (own_cancel) begin
                    stop_d  = 1'b1;
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (!disp_active) begin
                    done_d     = 1'b1;
                    enter_cool = 1'b1;
                end
            end
            COOLDOWN: begin
                if (cool_cnt_q + CNT_W'(1) >= COOL_LIM) begin
                    state_d = IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Release the grant and advance the fairness pointer past the owner.
        if (enter_cool) begin
            state_d    = COOLDOWN;
            grant_d    = '0;
            gid_d      = '0;
            cool_cnt_d = '0;
            rr_ptr_d   = next_ptr;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops everything at once, no stop pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ack_cnt_q  <= '0;
            cool_cnt_q <= '0;
            rr_ptr_q   <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            grant_q    <= '0;
            gid_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            grant_q    <= grant_d;
            gid_q      <= gid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    assign disp_start = start_q;
    assign disp_stop  = stop_q;
    assign grant      = grant_q;
    assign grant_id   = gid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign dbg_state  = state_q;

endmodule
